int_sequencer: RTL and testbench
================================

// Module: int_sequencer
// PURPOSE
//  Sequences interrupt entry and ERET exit around the 3-level interrupt coprocessor (int/ints, irs, ie, epc).
//  On entry it saves the resume PC, marks the level in-service, flushes the pipeline and jumps to the vector.
//  On exit it clears the in-service bit, restores the PC, and pops the nesting stack.
//  Sits between the core control unit, the PC mux and the coprocessor.
// PARAMETERS
//  VEC_BASE     32'h0000_0100  vector address of level 1
//  VEC_STRIDE   32'h0000_0010  byte spacing between level vectors
//  FLUSH_CYCLES 3              pipeline flush length in cycles, 1..7
// PORTS
//  clk            in   1   clock; FSM updates on posedge (coprocessor samples on negedge, mid-cycle)
//  rst_n          in   1   asynchronous, active-low reset
//  en             in   1   global run enable; 0 freezes all state
//  int            in   1   coprocessor: unmasked interrupt pending and ie=1
//  ints           in   3   coprocessor: highest pending level, 0..3
//  cp_epc         in   32  coprocessor EPC read
//  resume_pc      in   32  PC of the oldest not-yet-committed instruction
//  eret           in   1   ERET is committing this cycle (single-cycle pulse)
//  pipe_stall     in   1   pipeline is not at a safe boundary
//  cp_irs_w_mask  out  3   mask: OR-mask on set, AND-mask on clear
//  cp_irs_set_en  out  1   set in-service bits
//  cp_irs_clr_en  out  1   clear in-service bits and the matching pending bits
//  cp_ie_w_en     out  1   write ie
//  cp_ie_w_data   out  1   ie value
//  cp_epc_w_en    out  1   write epc
//  cp_epc_w_data  out  32  epc value
//  flush          out  1   kill all uncommitted instructions
//  redirect       out  1   one-cycle PC load strobe
//  redirect_pc    out  32  target PC for redirect
//  level          out  2   current in-service level, 0 = none
//  busy           out  1   FSM not in IDLE
//  err            out  1   one-cycle pulse when ERET arrives with an empty stack
// BEHAVIOUR
//  Reset: FSM=IDLE, stack empty, level=0, all outputs 0. An asserted reset aborts any sequence immediately.
//  en=0: state, stack and counter hold; all strobes held 0.
//  States:
//   IDLE: eret && depth>0 -> X_CLR; eret && depth==0 -> err=1, stay; else int && !pipe_stall -> E_SAVE.
//   E_SAVE: latch L=ints; push {cp_epc, level} on stack; epc<=resume_pc; ie<=0 -> E_MASK.
//   E_MASK: irs_set_en, mask=1<<(L-1); level<=L -> E_FLUSH.
//   E_FLUSH: flush=1 for FLUSH_CYCLES cycles (down-counter) -> E_JUMP.
//   E_JUMP: redirect=1; redirect_pc=VEC_BASE+(L-1)*VEC_STRIDE; ie<=1 -> IDLE.
//   X_CLR: latch ret_pc=cp_epc; irs_clr_en, mask=~(1<<(level-1)); ie<=0;
//          pop; epc<=popped epc; level<=popped level -> X_JUMP.
//   X_JUMP: flush=1 and redirect=1 in the same cycle; redirect_pc=ret_pc; ie<=1 -> IDLE.
//  Only one coprocessor write strobe of each kind is active per cycle; all strobes are 1-cycle pulses.
//  Entry latency: int to redirect = 3+FLUSH_CYCLES cycles. Exit latency: eret to redirect = 2 cycles.
//  Simultaneous eret and int in IDLE: eret wins; int is re-evaluated after return.
//  eret/int outside IDLE: ignored. Control guarantees eret does not arrive while busy.
//  Stack: 3 entries {32b epc, 2b level}. Push on a full stack cannot occur because levels nest strictly upward;
//  the bench asserts this condition never arises.
//  Vector arithmetic: 32-bit, wraps modulo 2^32, no overflow flag.
// STRUCTURE
//  Shared header Core.vh: state encodings, the VEC_* defaults, `INT_LEVELS=3.
//  Sub-module int_ret_stack: 3-deep LIFO with push, pop, depth and empty, async reset. All sequencing stays in int_sequencer.
// TESTING
//  1 int=1, ints=1, resume_pc=0x40 -> epc written 0x40; irs set mask 3'b001; flush 3 cycles; redirect to 0x100; level=1.
//  2 In level 1, ints=3 with int=1 -> push {0x40,1}; redirect 0x120; level=3;
//    then eret -> clr mask 3'b011; epc restored 0x40; level=1; redirect to saved epc.
//  3 eret and int high in the same IDLE cycle -> exit sequence runs first; entry starts after X_JUMP.
//  4 int=1 with pipe_stall=1 for 5 cycles -> no strobes; entry begins in the first cycle with pipe_stall=0.
//  5 eret with depth 0 -> err pulses once; no coprocessor writes; no redirect.
//  6 rst_n low during E_FLUSH -> asynchronous return to IDLE; flush drops immediately; stack empty; level=0.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// +----------------------------------------------------------------------------
// | int_sequencer_pkg : shared types, defaults and helpers for int_sequencer
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package int_sequencer_pkg;

  localparam int          INT_LEVELS           = 3;
  localparam int          STACK_DEPTH          = INT_LEVELS;
  localparam logic [31:0] VEC_BASE_DEFAULT     = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEFAULT   = 32'h0000_0010;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_E_SAVE  = 3'd1,
    S_E_MASK  = 3'd2,
    S_E_FLUSH = 3'd3,
    S_E_JUMP  = 3'd4,
    S_X_CLR   = 3'd5,
    S_X_JUMP  = 3'd6
  } state_t;

  typedef struct packed {
    logic [31:0] epc;
    logic [1:0]  level;
  } frame_t;

  // One-hot in-service bit for a level; level 0 maps to no bit.
  function automatic logic [2:0] level_mask(input logic [1:0] lvl);
    return (lvl == 2'd0) ? 3'b000 : (3'b001 << (lvl - 2'd1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_sequencer_ret_stack.sv
// +----------------------------------------------------------------------------
// | int_sequencer_ret_stack : 3-deep LIFO of {epc, level} return frames
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module int_sequencer_ret_stack
  import int_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  frame_t     push_data,
  output frame_t     top_data,
  output logic [1:0] depth,
  output logic       empty
);

  frame_t     mem [STACK_DEPTH];
  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && (cnt != 2'(STACK_DEPTH))) begin
      mem[cnt] <= push_data;
      cnt      <= cnt + 2'd1;
    end else if (pop && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign top_data = (cnt == 2'd0) ? '0 : mem[cnt - 2'd1];
  assign depth    = cnt;
  assign empty    = (cnt == 2'd0);

endmodule

`default_nettype wire

// File: rtl/int_sequencer.sv
// +----------------------------------------------------------------------------
// | int_sequencer : interrupt entry / ERET exit sequencer for a 3-level coprocessor
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_BASE     = VEC_BASE_DEFAULT,
  parameter logic [31:0] VEC_STRIDE   = VEC_STRIDE_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        int_pending,
  input  logic [2:0]  ints,
  input  logic [31:0] cp_epc,
  input  logic [31:0] resume_pc,
  input  logic        eret,
  input  logic        pipe_stall,
  output logic [2:0]  cp_irs_w_mask,
  output logic        cp_irs_set_en,
  output logic        cp_irs_clr_en,
  output logic        cp_ie_w_en,
  output logic        cp_ie_w_data,
  output logic        cp_epc_w_en,
  output logic [31:0] cp_epc_w_data,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [1:0]  level,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [1:0]  cur_lvl;
  logic [2:0]  flush_cnt;
  logic [31:0] ret_pc;
  logic        irs_set_q, irs_clr_q, ie_w_en_q, epc_w_en_q, flush_q, redirect_q, err_q;

  logic        push, pop, empty;
  logic [1:0]  depth;
  frame_t      top_data;
  logic [1:0]  lvl_in;
  logic [31:0] vec_pc;

  assign lvl_in = ints[2] ? 2'd3 : ints[1:0];
  assign vec_pc = VEC_BASE + (32'(cur_lvl) - 32'd1) * VEC_STRIDE;
  assign push   = en && (state == S_IDLE) && !eret && int_pending && !pipe_stall;
  assign pop    = en && (state == S_IDLE) && eret && (depth != 2'd0);

  int_sequencer_ret_stack u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data ({cp_epc, level}),
    .top_data  (top_data),
    .depth     (depth),
    .empty     (empty)
  );

  // Outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_lvl       <= 2'd0;
      flush_cnt     <= 3'd0;
      ret_pc        <= 32'd0;
      level         <= 2'd0;
      cp_irs_w_mask <= 3'd0;
      cp_ie_w_data  <= 1'b0;
      cp_epc_w_data <= 32'd0;
      redirect_pc   <= 32'd0;
      irs_set_q     <= 1'b0;
      irs_clr_q     <= 1'b0;
      ie_w_en_q     <= 1'b0;
      epc_w_en_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      err_q         <= 1'b0;
    end else if (en) begin
      irs_set_q  <= 1'b0;
      irs_clr_q  <= 1'b0;
      ie_w_en_q  <= 1'b0;
      epc_w_en_q <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eret) begin
            if (!empty) begin
              ret_pc        <= cp_epc;
              irs_clr_q     <= 1'b1;
              cp_irs_w_mask <= ~level_mask(level);
              ie_w_en_q     <= 1'b1;
              cp_ie_w_data  <= 1'b0;
              epc_w_en_q    <= 1'b1;
              cp_epc_w_data <= top_data.epc;
              level         <= top_data.level;
              state         <= S_X_CLR;
            end else begin
              err_q <= 1'b1;
            end
          end else if (int_pending && !pipe_stall) begin
            cur_lvl       <= lvl_in;
            epc_w_en_q    <= 1'b1;
            cp_epc_w_data <= resume_pc;
            ie_w_en_q     <= 1'b1;
            cp_ie_w_data  <= 1'b0;
            state         <= S_E_SAVE;
          end
        end
        S_E_SAVE: begin
          irs_set_q     <= 1'b1;
          cp_irs_w_mask <= level_mask(cur_lvl);
          level         <= cur_lvl;
          state         <= S_E_MASK;
        end
        S_E_MASK: begin
          flush_q   <= 1'b1;
          flush_cnt <= FLUSH_LAST;
          state     <= S_E_FLUSH;
        end
        S_E_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            redirect_q   <= 1'b1;
            redirect_pc  <= vec_pc;
            ie_w_en_q    <= 1'b1;
            cp_ie_w_data <= 1'b1;
            state        <= S_E_JUMP;
          end else begin
            flush_q   <= 1'b1;
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        S_X_CLR: begin
          flush_q      <= 1'b1;
          redirect_q   <= 1'b1;
          redirect_pc  <= ret_pc;
          ie_w_en_q    <= 1'b1;
          cp_ie_w_data <= 1'b1;
          state        <= S_X_JUMP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked while frozen so a held state never re-fires a write.
  assign cp_irs_set_en = irs_set_q & en;
  assign cp_irs_clr_en = irs_clr_q & en;
  assign cp_ie_w_en    = ie_w_en_q & en;
  assign cp_epc_w_en   = epc_w_en_q & en;
  assign flush         = flush_q & en;
  assign redirect      = redirect_q & en;
  assign err           = err_q & en;
  assign busy          = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// +----------------------------------------------------------------------------
// | tb_int_sequencer : scoreboard bench for int_sequencer with an EPC model
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_int_sequencer;

  localparam int F = 3;
  localparam int K_EPC = 0, K_IE = 1, K_SET = 2, K_CLR = 3, K_FLUSH = 4, K_REDIR = 5, K_ERR = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        irq = 1'b0;
  logic [2:0]  ints = 3'd0;
  logic [31:0] cp_epc;
  logic [31:0] resume_pc = 32'd0;
  logic        eret = 1'b0;
  logic        pipe_stall = 1'b0;
  logic [2:0]  cp_irs_w_mask;
  logic        cp_irs_set_en, cp_irs_clr_en, cp_ie_w_en, cp_ie_w_data, cp_epc_w_en;
  logic [31:0] cp_epc_w_data, redirect_pc;
  logic        flush, redirect, busy, err;
  logic [1:0]  level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  int_sequencer #(
    .VEC_BASE     (32'h0000_0100),
    .VEC_STRIDE   (32'h0000_0010),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .int_pending   (irq),
    .ints          (ints),
    .cp_epc        (cp_epc),
    .resume_pc     (resume_pc),
    .eret          (eret),
    .pipe_stall    (pipe_stall),
    .cp_irs_w_mask (cp_irs_w_mask),
    .cp_irs_set_en (cp_irs_set_en),
    .cp_irs_clr_en (cp_irs_clr_en),
    .cp_ie_w_en    (cp_ie_w_en),
    .cp_ie_w_data  (cp_ie_w_data),
    .cp_epc_w_en   (cp_epc_w_en),
    .cp_epc_w_data (cp_epc_w_data),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .level         (level),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Coprocessor EPC register, written mid-cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) cp_epc <= 32'd0;
    else if (cp_epc_w_en) cp_epc <= cp_epc_w_data;
  end

  always @(posedge clk) begin
    if (rst_n && dut.push && (dut.depth == 2'd3)) begin
      failures++;
      $display("FAIL stack_full_push: push with depth=%0d, required depth<3", dut.depth);
    end
  end

  // Scoreboard: every observed strobe must match the oldest expected event.
  logic        mon_on;
  logic [31:0] mon_d;
  ev_t         mon_ev;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 7; k++) begin
        mon_on = 1'b0;
        mon_d  = 32'd0;
        case (k)
          K_EPC:   begin mon_on = cp_epc_w_en;   mon_d = cp_epc_w_data; end
          K_IE:    begin mon_on = cp_ie_w_en;    mon_d = {31'd0, cp_ie_w_data}; end
          K_SET:   begin mon_on = cp_irs_set_en; mon_d = {29'd0, cp_irs_w_mask}; end
          K_CLR:   begin mon_on = cp_irs_clr_en; mon_d = {29'd0, cp_irs_w_mask}; end
          K_FLUSH: begin mon_on = flush; end
          K_REDIR: begin mon_on = redirect;      mon_d = redirect_pc; end
          default: begin mon_on = err; end
        endcase
        if (mon_on) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_unexpected: got kind=%0d cyc=%0d data=%h, required no event", k, cyc, mon_d);
          end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.kind !== k || mon_ev.cyc !== cyc || mon_ev.data !== mon_d) begin
              failures++;
              $display("FAIL scoreboard: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                       k, cyc, mon_d, mon_ev.kind, mon_ev.cyc, mon_ev.data);
            end
          end
        end
      end
    end
  end

  function automatic void expect_ev(int kind, int c, logic [31:0] d);
    ev_t e;
    int  i;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind))) i++;
    exp_q.insert(i, e);
  endfunction

  // Entry sampled at the edge ending cycle k.
  function automatic void expect_entry(int k, logic [2:0] m, logic [31:0] pc, logic [31:0] vec);
    expect_ev(K_EPC, k + 1, pc);
    expect_ev(K_IE, k + 1, 32'd0);
    expect_ev(K_SET, k + 2, {29'd0, m});
    for (int i = 0; i < F; i++) expect_ev(K_FLUSH, k + 3 + i, 32'd0);
    expect_ev(K_REDIR, k + 3 + F, vec);
    expect_ev(K_IE, k + 3 + F, 32'd1);
  endfunction

  function automatic void expect_exit(int k, logic [2:0] m, logic [31:0] epc_back, logic [31:0] ret);
    expect_ev(K_CLR, k + 1, {29'd0, m});
    expect_ev(K_IE, k + 1, 32'd0);
    expect_ev(K_EPC, k + 1, epc_back);
    expect_ev(K_FLUSH, k + 2, 32'd0);
    expect_ev(K_REDIR, k + 2, ret);
    expect_ev(K_IE, k + 2, 32'd1);
  endfunction

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_eret(output int k);
    @(posedge clk); #1;
    k = cyc;
    eret = 1'b1;
    @(posedge clk); #1;
    eret = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cp_irs_set_en, cp_irs_clr_en, cp_ie_w_en, cp_epc_w_en, flush, redirect, err} !== 7'd0) begin
      failures++; $display("FAIL reset_strobes: got %b, required 0", {cp_irs_set_en, cp_irs_clr_en, cp_ie_w_en, cp_epc_w_en, flush, redirect, err});
    end
    checks++;
    if (level !== 2'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_state: got level=%0d busy=%b, required 0 0", level, busy);
    end
    checks++;
    if (redirect_pc !== 32'd0 || cp_epc_w_data !== 32'd0 || cp_irs_w_mask !== 3'd0) begin
      failures++; $display("FAIL reset_data: got rpc=%h epc=%h mask=%b, required 0", redirect_pc, cp_epc_w_data, cp_irs_w_mask);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_entry();
    int k;
    @(posedge clk); #1;
    k = cyc; irq = 1'b1; ints = 3'd1; resume_pc = 32'h40;
    expect_entry(k, 3'b001, 32'h40, 32'h100);
    @(posedge clk); #1;
    irq = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL entry_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (level !== 2'd1 || busy !== 1'b0 || dut.depth !== 2'd1) begin
      failures++; $display("FAIL entry_state: got level=%0d busy=%b depth=%0d, required 1 0 1", level, busy, dut.depth);
    end
  endtask

  task automatic test_nested();
    int k;
    @(posedge clk); #1;
    k = cyc; irq = 1'b1; ints = 3'd3; resume_pc = 32'h80;
    expect_entry(k, 3'b100, 32'h80, 32'h120);
    @(posedge clk); #1;
    irq = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL nested_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (level !== 2'd3 || dut.depth !== 2'd2 || dut.top_data !== {32'h40, 2'd1}) begin
      failures++; $display("FAIL nested_push: got level=%0d depth=%0d top=%h, required 3 2 %h", level, dut.depth, dut.top_data, {32'h40, 2'd1});
    end
    pulse_eret(k);
    expect_exit(k, 3'b011, 32'h40, 32'h80);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL nested_exit_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (level !== 2'd1 || dut.depth !== 2'd1 || cp_epc !== 32'h40) begin
      failures++; $display("FAIL nested_pop: got level=%0d depth=%0d epc=%h, required 1 1 00000040", level, dut.depth, cp_epc);
    end
  endtask

  task automatic test_eret_int_same();
    int k;
    @(posedge clk); #1;
    k = cyc; eret = 1'b1; irq = 1'b1; ints = 3'd2; resume_pc = 32'h200;
    expect_exit(k, 3'b110, 32'h0, 32'h40);
    expect_entry(k + 3, 3'b010, 32'h200, 32'h110);
    @(posedge clk); #1;
    eret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    irq = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL eret_int_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (level !== 2'd2 || dut.depth !== 2'd1) begin
      failures++; $display("FAIL eret_int_state: got level=%0d depth=%0d, required 2 1", level, dut.depth);
    end
    pulse_eret(k);
    expect_exit(k, 3'b101, 32'h0, 32'h200);
    drain();
    checks++;
    if (exp_q.size() != 0 || level !== 2'd0 || dut.depth !== 2'd0) begin
      failures++; $display("FAIL eret_int_return: got pending=%0d level=%0d depth=%0d, required 0 0 0", exp_q.size(), level, dut.depth);
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    int k;
    @(posedge clk); #1;
    k = cyc; pipe_stall = 1'b1; irq = 1'b1; ints = 3'd1; resume_pc = 32'h300;
    expect_entry(k + 5, 3'b001, 32'h300, 32'h100);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL stall_hold: got busy=%b, required 0", busy); end
    pipe_stall = 1'b0;
    @(posedge clk); #1;
    irq = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    pulse_eret(k);
    expect_exit(k, 3'b110, 32'h0, 32'h300);
    drain();
    checks++;
    if (exp_q.size() != 0 || level !== 2'd0) begin
      failures++; $display("FAIL stall_return: got pending=%0d level=%0d, required 0 0", exp_q.size(), level);
      exp_q.delete();
    end
  endtask

  task automatic test_err();
    int k;
    pulse_eret(k);
    expect_ev(K_ERR, k + 1, 32'd0);
    drain();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || level !== 2'd0 || dut.depth !== 2'd0) begin
      failures++; $display("FAIL err_pulse: got pending=%0d busy=%b level=%0d depth=%0d, required 0 0 0 0", exp_q.size(), busy, level, dut.depth);
      exp_q.delete();
    end
  endtask

  task automatic test_enable_freeze();
    int k;
    @(posedge clk); #1;
    k = cyc; irq = 1'b1; ints = 3'd2; resume_pc = 32'h600;
    expect_ev(K_EPC, k + 1, 32'h600);
    expect_ev(K_IE, k + 1, 32'd0);
    expect_ev(K_SET, k + 2, 32'b010);
    for (int i = 7; i < 10; i++) expect_ev(K_FLUSH, k + i, 32'd0);
    expect_ev(K_REDIR, k + 10, 32'h110);
    expect_ev(K_IE, k + 10, 32'd1);
    @(posedge clk); #1;
    irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL freeze_gate: got flush=%b busy=%b, required 0 1", flush, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
    drain();
    checks++;
    if (exp_q.size() != 0 || level !== 2'd2) begin
      failures++; $display("FAIL freeze_resume: got pending=%0d level=%0d, required 0 2", exp_q.size(), level);
      exp_q.delete();
    end
    pulse_eret(k);
    expect_exit(k, 3'b101, 32'h0, 32'h600);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL freeze_exit: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    int k;
    @(posedge clk); #1;
    k = cyc; irq = 1'b1; ints = 3'd1; resume_pc = 32'h500;
    expect_ev(K_EPC, k + 1, 32'h500);
    expect_ev(K_IE, k + 1, 32'd0);
    expect_ev(K_SET, k + 2, 32'b001);
    @(posedge clk); #1;
    irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (flush !== 1'b1 || level !== 2'd1) begin
      failures++; $display("FAIL areset_pre: got flush=%b level=%0d, required 1 1", flush, level);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || busy !== 1'b0 || level !== 2'd0 || dut.depth !== 2'd0) begin
      failures++; $display("FAIL areset_abort: got flush=%b busy=%b level=%0d depth=%0d, required 0 0 0 0", flush, busy, level, dut.depth);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL areset_events: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL areset_after: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_nested();
    test_eret_int_same();
    test_stall();
    test_err();
    test_enable_freeze();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
